// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. One full-add slice is
// sequenced over WIDTH cycles, LSB first, via an IDLE/RUN/DONE FSM.
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' port:
//   sub=1 gives a-b (two's complement), and cout=1 means no borrow.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sub_eff;
  logic             accept;
  logic             last;
  logic             sum_bit;
  logic             carry_nxt;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // Full-add slice on the operand LSBs, plus the control decodes.
  always_comb begin
    sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    accept    = start && (state != RUN);
    last      = (state == RUN) && (cnt == CW'(WIDTH - 1));
    busy      = (state == RUN);
    done      = (state == DONE);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands, shift one bit per RUN cycle, and publish the
  // result only on the final edge so partial sums never reach sum/cout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub_eff ? ~b : b;
      acc   <= '0;
      carry <= sub_eff;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= {sum_bit, acc[WIDTH-1:1]};
      carry <= carry_nxt;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= {sum_bit, acc[WIDTH-1:1]};
        cout <= carry_nxt;
      end
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH SHALL be declared: default 8, operand/result width in bits, legal range 2..32.
REQ-002 Port clk SHALL be: input, 1, single clock; all state updates on rising edge.
REQ-003 Port rst SHALL be: input, 1, asynchronous active-high reset.
REQ-004 Port start SHALL be: input, 1, request to begin an addition; sampled on rising clk edge.
REQ-005 Port a SHALL be: input, WIDTH, operand A; captured when start is accepted.
REQ-006 Port b SHALL be: input, WIDTH, operand B; captured when start is accepted.
REQ-007 Port busy SHALL be: output, 1, high while in RUN.
REQ-008 Port done SHALL be: output, 1, one-cycle pulse marking sum/cout valid.
REQ-009 Port sum SHALL be: output, WIDTH, result; held from done until next accepted start.
REQ-010 Port cout SHALL be: output, 1, final carry out; held like sum.
REQ-011 Clocking and reset SHALL be one clock (clk) with asynchronous active-high reset (rst).

Function
REQ-012 The block SHALL sequence a single 1-bit full-add datapath (a_i, b_i, carry register) over WIDTH cycles, LSB first.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, encoded in 2 bits.
REQ-014 start SHALL be accepted only in IDLE or DONE; on acceptance a and b are latched into shift registers, carry is cleared, bit counter=0, and state goes to RUN.
REQ-015 start in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-016 Each RUN edge SHALL produce sum_bit = a0^b0^c and c' = a0&b0 | c&(a0^b0), shift sum_bit into result MSB, shift operands right, and increment the counter.
REQ-017 After the WIDTH-th RUN edge the state SHALL go to DONE; sum holds the full result and cout the final carry.
REQ-018 Latency SHALL be: start-accepting edge at cycle 0; done high during cycle WIDTH (after edge WIDTH), for exactly one cycle.
REQ-019 DONE SHALL go to IDLE on the next edge without start, or to RUN with start (back-to-back; zero idle cycles).
REQ-020 sum/cout SHALL NOT change in IDLE/DONE; intermediate shift contents are not visible until done.
REQ-021 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within an operation.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH, with the carry out of the MSB reported on cout.

Reset
REQ-023 While rst is high, state SHALL be IDLE, and busy=0, done=0, sum=0, cout=0, carry=0, counter=0, independent of clk.
REQ-024 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst release is accepted normally.

Configuration
REQ-025 Macro SERIAL_ADD_SUB_EN SHALL control subtraction support.
REQ-026 With SERIAL_ADD_SUB_EN defined, the block SHALL add input port sub (1 bit, captured with operands); sub=1 latches ~b and presets carry=1, giving sum=a-b mod 2^WIDTH with cout=1 meaning no borrow; sub=0 behaves as plain add.
REQ-027 With SERIAL_ADD_SUB_EN undefined, the block SHALL have no sub port and SHALL add only; timing is identical in both builds.

Verification (WIDTH=8)
REQ-028 Bench SHALL drive a=0x5A, b=0x3C, start 1 cycle -> busy high 8 cycles, done at cycle 8, sum=0x96, cout=0.
REQ-029 Bench SHALL drive a=0xFF, b=0x01 -> sum=0x00, cout=1; then a=0x00, b=0x00 -> sum=0x00, cout=0.
REQ-030 Bench SHALL assert start=1 continuously with new operands each DONE -> consecutive results every 9 cycles, and start during RUN is ignored (operands changed mid-RUN do not affect sum).
REQ-031 Bench SHALL assert rst at cycle 4 of RUN -> busy/done/sum/cout=0 immediately, no done pulse; next start 0x01+0x02 -> sum=0x03.
REQ-032 Bench SHALL run with SERIAL_ADD_SUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1; a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
